// File: rtl/mem_arbiter_if.sv
// Bundle of the IF/D requester ports and the single-port memory port.
// slave is the arbiter's view; master is the requesters/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_adr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_adr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_datain;
  logic              mem_w;
  logic              mem_r;
  logic [DATA_W-1:0] mem_dataout;

  modport slave (
    input  if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_dataout,
    output if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
           mem_adr, mem_datain, mem_w, mem_r
  );

  modport master (
    output if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_dataout,
    input  if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
           mem_adr, mem_datain, mem_w, mem_r
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between IF (port 0) and D (port 1).
// One transaction per IDLE -> ACCESS -> RESP pass; out-of-range addresses never touch memory.

// Per-port response holding register: captured at the close of ACCESS, held until the next capture.
module mem_arbiter_port #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic              cap_err,
  input  logic [DATA_W-1:0] cap_data,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (cap) begin
      rdata <= cap_data;
      err   <= cap_err;
    end
  end
endmodule

module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int NUM_PORTS = 2;
  localparam int PORT_IF   = 0;
  localparam int PORT_D    = 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              port;
    logic [ADDR_W-1:0] adr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic              err;
  } req_t;

  state_t state, state_nxt;
  req_t   cur, cur_nxt;
  logic   last_grant, last_grant_nxt;
  logic   gnt;
  logic   acc;
  logic   [NUM_PORTS-1:0] req;
  logic   [NUM_PORTS-1:0] cap;
  logic   [NUM_PORTS-1:0] err_arr;
  logic   [NUM_PORTS-1:0][DATA_W-1:0] rdata_arr;
  logic   [ADDR_W-1:0] sel_adr;
  logic   [DATA_W-1:0] cap_data;

  assign req = {bus.d_req, bus.if_req};

  // On a tie the port that did not win last time goes; single requester always wins.
  always_comb begin
    gnt = req[PORT_D];
    if (req == 2'b11) gnt = ~last_grant;
  end

  assign sel_adr = gnt ? bus.d_adr : bus.if_adr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= '0;
      last_grant <= 1'(PORT_IF);
    end else begin
      state      <= state_nxt;
      cur        <= cur_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cur_nxt        = cur;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (|req) begin
          cur_nxt.port   = gnt;
          cur_nxt.adr    = sel_adr;
          cur_nxt.we     = gnt & bus.d_we;
          cur_nxt.wdata  = gnt ? bus.d_wdata : '0;
          cur_nxt.err    = (sel_adr >= DEPTH_A);
          last_grant_nxt = gnt;
          state_nxt      = ACCESS;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory is only driven during ACCESS; everything is zero otherwise.
  assign acc            = (state == ACCESS);
  assign bus.mem_adr    = acc ? cur.adr   : '0;
  assign bus.mem_datain = acc ? cur.wdata : '0;
  assign bus.mem_w      = acc &  cur.we & ~cur.err;
  assign bus.mem_r      = acc & ~cur.we & ~cur.err;

  // Stores and rejected accesses return zero data.
  assign cap_data = (cur.we | cur.err) ? '0 : bus.mem_dataout;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign cap[p] = acc && (cur.port == 1'(p));
    mem_arbiter_port #(.DATA_W(DATA_W)) u_port (
      .clk      (clk),
      .rst      (rst),
      .cap      (cap[p]),
      .cap_err  (cur.err),
      .cap_data (cap_data),
      .rdata    (rdata_arr[p]),
      .err      (err_arr[p])
    );
  end

  assign bus.if_ready = (state == RESP) && (cur.port == 1'(PORT_IF));
  assign bus.d_ready  = (state == RESP) && (cur.port == 1'(PORT_D));
  assign bus.if_rdata = rdata_arr[PORT_IF];
  assign bus.if_err   = err_arr[PORT_IF];
  assign bus.d_rdata  = rdata_arr[PORT_D];
  assign bus.d_err    = err_arr[PORT_D];
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural 256x64 memory, response monitor, expected-response queue.
module tb_mem_arbiter;
  typedef struct packed {
    logic        port;
    logic [63:0] rdata;
    logic        err;
  } rsp_t;

  logic clk;
  logic rst;
  logic preload;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   mem_w_cnt = 0;
  int   both_cnt = 0;

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  int   cyc_q[$];

  logic [63:0] mem [256];

  mem_arbiter_if bus ();

  mem_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational read, write at posedge, ignores rst.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 64'(i);
    end else if (bus.mem_w) begin
      mem[bus.mem_adr[7:0]] <= bus.mem_datain;
    end
  end
  assign bus.mem_dataout = mem[bus.mem_adr[7:0]];

  // Response monitor: records what the DUT returns, comparisons happen in the tests.
  always @(negedge clk) begin
    if (bus.if_ready) begin
      obs_q.push_back(rsp_t'{1'b0, bus.if_rdata, bus.if_err});
      cyc_q.push_back(cyc);
    end
    if (bus.d_ready) begin
      obs_q.push_back(rsp_t'{1'b1, bus.d_rdata, bus.d_err});
      cyc_q.push_back(cyc);
    end
    if (bus.mem_w) mem_w_cnt <= mem_w_cnt + 1;
    if (bus.if_ready && bus.d_ready) both_cnt <= both_cnt + 1;
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    preload = 1'b0;
  endtask

  // Waits (bounded) for the next recorded response; returns #1 after a posedge.
  task automatic get_obs(output bit to, output rsp_t o, output int c);
    to = 1'b1;
    o  = '0;
    c  = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (obs_q.size() > 0) begin
        to = 1'b0;
        break;
      end
    end
    #1;
    if (!to) begin
      o = obs_q.pop_front();
      c = cyc_q.pop_front();
    end
  endtask

  task automatic d_issue(input logic [63:0] adr, input logic we, input logic [63:0] wdata);
    @(posedge clk);
    #1;
    bus.d_adr   = adr;
    bus.d_we    = we;
    bus.d_wdata = wdata;
    bus.d_req   = 1'b1;
  endtask

  task automatic test_reset();
    preload = 1'b1;
    do_reset();
    @(negedge clk);
    total++;
    if ({bus.if_ready, bus.d_ready, bus.if_err, bus.d_err} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000", {bus.if_ready, bus.d_ready, bus.if_err, bus.d_err});
    end
    total++;
    if ({bus.if_rdata, bus.d_rdata} !== 128'd0) begin
      bad++;
      $display("FAIL reset_rdata: got %h %h want 0", bus.if_rdata, bus.d_rdata);
    end
    total++;
    if ({bus.mem_w, bus.mem_r, bus.mem_adr, bus.mem_datain} !== 130'd0) begin
      bad++;
      $display("FAIL reset_mem: got w=%b r=%b adr=%h din=%h want 0", bus.mem_w, bus.mem_r, bus.mem_adr, bus.mem_datain);
    end
  endtask

  task automatic test_if_read();
    bit to; rsp_t o, e; int c, t0;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.if_adr = 64'd5;
    bus.if_req = 1'b1;
    exp_q.push_back(rsp_t'{1'b0, 64'd5, 1'b0});
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.mem_r, bus.mem_w, bus.mem_adr} !== {1'b1, 1'b0, 64'd5}) begin
      bad++;
      $display("FAIL if_read_access: got r=%b w=%b adr=%h want r=1 w=0 adr=5", bus.mem_r, bus.mem_w, bus.mem_adr);
    end
    get_obs(to, o, c);
    bus.if_req = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (to || o !== e) begin
      bad++;
      $display("FAIL if_read: timeout=%0d got %h want %h", to, o, e);
    end
    total++;
    if (c !== t0 + 2) begin
      bad++;
      $display("FAIL if_read_latency: ready at cycle %0d want %0d", c, t0 + 2);
    end
  endtask

  task automatic test_store_load();
    bit to; rsp_t o, e; int c, m0;
    m0 = mem_w_cnt;
    d_issue(64'd10, 1'b1, 64'hDEAD);
    exp_q.push_back(rsp_t'{1'b1, 64'd0, 1'b0});
    get_obs(to, o, c);
    bus.d_req = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (to || o !== e) begin
      bad++;
      $display("FAIL store10: timeout=%0d got %h want %h", to, o, e);
    end
    d_issue(64'd10, 1'b0, 64'd0);
    exp_q.push_back(rsp_t'{1'b1, 64'hDEAD, 1'b0});
    get_obs(to, o, c);
    bus.d_req = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (to || o !== e) begin
      bad++;
      $display("FAIL load10: timeout=%0d got %h want %h", to, o, e);
    end
    total++;
    if (mem_w_cnt - m0 !== 1) begin
      bad++;
      $display("FAIL store_mem_w_cycles: got %0d want 1", mem_w_cnt - m0);
    end
  endtask

  task automatic test_error();
    bit to; rsp_t o, e; int c, m0;
    logic [63:0] adr_t [5] = '{64'd300, 64'd300, 64'd256, 64'd255, 64'h1_0000_0005};
    logic        we_t  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rsp_t        rsp_t_[5] = '{rsp_t'{1'b1, 64'd0, 1'b1}, rsp_t'{1'b1, 64'd0, 1'b1},
                               rsp_t'{1'b1, 64'd0, 1'b1}, rsp_t'{1'b1, 64'd255, 1'b0},
                               rsp_t'{1'b1, 64'd0, 1'b1}};
    m0 = mem_w_cnt;
    for (int k = 0; k < 5; k++) begin
      d_issue(adr_t[k], we_t[k], 64'hBAD0 + 64'(k));
      exp_q.push_back(rsp_t_[k]);
      get_obs(to, o, c);
      bus.d_req = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (to || o !== e) begin
        bad++;
        $display("FAIL err_case%0d adr=%h: timeout=%0d got %h want %h", k, adr_t[k], to, o, e);
      end
    end
    total++;
    if (mem_w_cnt - m0 !== 0) begin
      bad++;
      $display("FAIL err_mem_w: got %0d write cycles want 0", mem_w_cnt - m0);
    end
  endtask

  task automatic test_back_to_back();
    bit to; rsp_t o, e; int c1, c2;
    @(posedge clk);
    #1;
    bus.if_adr = 64'd20;
    bus.if_req = 1'b1;
    exp_q.push_back(rsp_t'{1'b0, 64'd20, 1'b0});
    get_obs(to, o, c1);
    bus.if_adr = 64'd21;
    e = exp_q.pop_front();
    total++;
    if (to || o !== e) begin
      bad++;
      $display("FAIL b2b_first: timeout=%0d got %h want %h", to, o, e);
    end
    exp_q.push_back(rsp_t'{1'b0, 64'd21, 1'b0});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (bus.if_rdata !== 64'd20 || bus.if_ready !== 1'b0) begin
        bad++;
        $display("FAIL b2b_hold%0d: got rdata=%h ready=%b want 20 0", k, bus.if_rdata, bus.if_ready);
      end
    end
    get_obs(to, o, c2);
    bus.if_req = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (to || o !== e) begin
      bad++;
      $display("FAIL b2b_second: timeout=%0d got %h want %h", to, o, e);
    end
    total++;
    if (c2 - c1 !== 3) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d cycles want 3", c2 - c1);
    end
  endtask

  task automatic test_reset_mid();
    bit to; rsp_t o, e; int c;
    @(posedge clk);
    #1;
    bus.if_adr = 64'd7;
    bus.if_req = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.mem_r !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_access: got mem_r=%b want 1", bus.mem_r);
    end
    rst = 1'b1;
    bus.if_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (obs_q.size() !== 0) begin
      bad++;
      $display("FAIL rstmid_no_ready: got %0d responses want 0", obs_q.size());
    end
    total++;
    if (bus.if_rdata !== 64'd0) begin
      bad++;
      $display("FAIL rstmid_rdata: got %h want 0", bus.if_rdata);
    end
    @(posedge clk);
    #1;
    bus.if_adr = 64'd3;
    bus.d_adr  = 64'd4;
    bus.d_we   = 1'b0;
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    exp_q.push_back(rsp_t'{1'b1, 64'd4, 1'b0});
    exp_q.push_back(rsp_t'{1'b0, 64'd3, 1'b0});
    for (int k = 0; k < 2; k++) begin
      get_obs(to, o, c);
      if (k == 0) bus.d_req = 1'b0;
      else bus.if_req = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (to || o !== e) begin
        bad++;
        $display("FAIL rstmid_grant%0d: timeout=%0d got %h want %h", k, to, o, e);
      end
    end
  endtask

  task automatic test_round_robin();
    bit to; rsp_t o, e; int c, prev, t0;
    do_reset();
    @(posedge clk);
    #1;
    t0 = cyc;
    prev = t0 - 1;
    bus.if_adr = 64'd1;
    bus.d_adr  = 64'd2;
    bus.d_we   = 1'b0;
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    for (int k = 0; k < 4; k++)
      exp_q.push_back((k % 2 == 0) ? rsp_t'{1'b1, 64'd2, 1'b0} : rsp_t'{1'b0, 64'd1, 1'b0});
    for (int k = 0; k < 4; k++) begin
      get_obs(to, o, c);
      e = exp_q.pop_front();
      total++;
      if (to || o !== e) begin
        bad++;
        $display("FAIL rr_grant%0d: timeout=%0d got %h want %h", k, to, o, e);
      end
      total++;
      if (c - prev !== ((k == 0) ? 3 : 3)) begin
        bad++;
        $display("FAIL rr_spacing%0d: got %0d cycles want 3", k, c - prev);
      end
      prev = c;
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (obs_q.size() !== 0 || both_cnt !== 0) begin
      bad++;
      $display("FAIL rr_tail: got extra=%0d both_ready=%0d want 0 0", obs_q.size(), both_cnt);
    end
  endtask

  initial begin
    rst         = 1'b1;
    preload     = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_adr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_adr   = '0;
    bus.d_wdata = '0;
    test_reset();
    test_if_read();
    test_store_load();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_round_robin();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
